wback_trace_buffer: RTL and testbench

//   Consumer end of the processor's register-writeback port (write_en, wback_addr, reg_w_data).

---
 rtl/wback_trace_buffer_if.sv | 33 +++
 rtl/wback_trace_buffer.sv | 152 +++++++++++++++
 tb/tb_wback_trace_buffer.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/wback_trace_buffer_if.sv
// rtl/wback_trace_buffer_if.sv - writeback capture, control and drain-port bundle for the trace buffer
// master: processor, host or bench side; slave: the trace buffer itself.
interface wback_trace_buffer_if #(
  parameter int AW = 4
);
  logic          write_en;
  logic [2:0]    wback_addr;
  logic [15:0]   reg_w_data;
  logic          start;
  logic          stop;
  logic          trig_en;
  logic [2:0]    trig_addr;
  logic [3:0]    post_cnt;
  logic          rd_ready;
  logic          rd_valid;
  logic [15:0]   rd_stamp;
  logic [2:0]    rd_addr;
  logic [15:0]   rd_data;
  logic [AW:0]   count;
  logic          overflow;
  logic          triggered;
  logic [1:0]    state;

  modport master (
    output write_en, wback_addr, reg_w_data, start, stop, trig_en, trig_addr, post_cnt, rd_ready,
    input  rd_valid, rd_stamp, rd_addr, rd_data, count, overflow, triggered, state
  );

  modport slave (
    input  write_en, wback_addr, reg_w_data, start, stop, trig_en, trig_addr, post_cnt, rd_ready,
    output rd_valid, rd_stamp, rd_addr, rd_data, count, overflow, triggered, state
  );
endinterface

// File: rtl/wback_trace_buffer.sv
// rtl/wback_trace_buffer.sv - timestamped register-writeback trace FIFO with trigger and post-trigger stop
// Capture runs in CAPTURE/POST; the read port drains the FIFO in any state.
module wback_trace_buffer #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic               clk,
  input  logic               reset,
  wback_trace_buffer_if.slave bus
);
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_POST    = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  typedef struct packed {
    logic [15:0] stamp;
    logic [2:0]  addr;
    logic [15:0] data;
  } entry_t;

  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  state_e        state_q, state_d;
  logic [15:0]   stamp_q;
  logic [3:0]    post_q, post_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          triggered_q, triggered_d;
  entry_t        mem_q [DEPTH];
  entry_t        head;

  logic          empty, full, flush, qualified, do_pop, do_push, trig_hit;

  // A start or stop edge swallows any writeback on that same edge.
  always_comb begin
    empty     = (count_q == '0);
    full      = (count_q == FULL_CNT);
    flush     = bus.start && !bus.stop;
    qualified = bus.write_en && !bus.start && !bus.stop &&
                ((state_q == ST_CAPTURE) || (state_q == ST_POST));
    do_pop    = !empty && bus.rd_ready;
    do_push   = qualified && (!full || do_pop);
    trig_hit  = qualified && (state_q == ST_CAPTURE) && bus.trig_en &&
                (bus.wback_addr == bus.trig_addr);
  end

  always_comb begin
    state_d     = state_q;
    post_d      = post_q;
    triggered_d = triggered_q;
    if (bus.stop) begin
      state_d = ST_IDLE;
    end else if (bus.start) begin
      state_d     = ST_CAPTURE;
      triggered_d = 1'b0;
    end else begin
      case (state_q)
        ST_CAPTURE: begin
          if (trig_hit) begin
            triggered_d = 1'b1;
            post_d      = bus.post_cnt;
            state_d     = (bus.post_cnt == 4'd0) ? ST_DONE : ST_POST;
          end
        end
        ST_POST: begin
          // Dropped writes still count towards the post-trigger budget.
          if (qualified) begin
            post_d = post_q - 1'b1;
            if (post_q == 4'd1) begin
              state_d = ST_DONE;
            end
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end else begin
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (do_push) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
      if (qualified && !do_push) begin
        overflow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      stamp_q     <= '0;
      post_q      <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      triggered_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      stamp_q     <= stamp_q + 16'd1;
      post_q      <= post_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      triggered_q <= triggered_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && do_push) begin
      mem_q[wr_ptr_q] <= '{stamp: stamp_q, addr: bus.wback_addr, data: bus.reg_w_data};
    end
  end

  // Head fields are forced to zero while empty so stale slots never leak out.
  assign head          = mem_q[rd_ptr_q];
  assign bus.rd_valid  = !empty;
  assign bus.rd_stamp  = empty ? 16'd0 : head.stamp;
  assign bus.rd_addr   = empty ? 3'd0  : head.addr;
  assign bus.rd_data   = empty ? 16'd0 : head.data;
  assign bus.count     = count_q;
  assign bus.overflow  = overflow_q;
  assign bus.triggered = triggered_q;
  assign bus.state     = state_q;
endmodule

// File: tb/tb_wback_trace_buffer.sv
// tb/tb_wback_trace_buffer.sv - self-checking bench for wback_trace_buffer
// Directed scenarios plus a randomized run against a queue-based reference model.
module tb_wback_trace_buffer;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  typedef struct packed {
    logic [15:0] stamp;
    logic [2:0]  addr;
    logic [15:0] data;
  } ent_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  wback_trace_buffer_if #(.AW(AW)) bus ();
  wback_trace_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

  ent_t mq[$];
  int   m_stamp, m_state, m_post;
  bit   m_ovf, m_trig;
  int   checks, failures;

  task automatic model_edge();
    ent_t e;
    bit   cap, pop;
    if (reset) begin
      mq.delete(); m_stamp = 0; m_state = 0; m_post = 0; m_ovf = 0; m_trig = 0;
      return;
    end
    e.stamp = 16'(m_stamp); e.addr = bus.wback_addr; e.data = bus.reg_w_data;
    cap = bus.write_en && (m_state == 1 || m_state == 2) && !bus.start && !bus.stop;
    pop = (mq.size() != 0) && bus.rd_ready;
    if (bus.start && !bus.stop) begin
      mq.delete(); m_ovf = 0; m_trig = 0; m_state = 1;
    end else begin
      if (pop) void'(mq.pop_front());
      if (cap) begin
        if (mq.size() < DEPTH) mq.push_back(e);
        else m_ovf = 1;
      end
      if (bus.stop) m_state = 0;
      else if (cap && m_state == 1 && bus.trig_en && bus.wback_addr == bus.trig_addr) begin
        m_trig = 1;
        if (bus.post_cnt == 0) m_state = 3;
        else begin m_state = 2; m_post = int'(bus.post_cnt); end
      end else if (cap && m_state == 2) begin
        m_post--;
        if (m_post == 0) m_state = 3;
      end
    end
    m_stamp = (m_stamp + 1) % 65536;
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [2:0] a, input logic [15:0] d);
    bus.write_en = 1'b1; bus.wback_addr = a; bus.reg_w_data = d;
    step();
    bus.write_en = 1'b0;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; step(); step(); reset = 1'b0;
    checks++; if (bus.state !== 2'd0) begin failures++; $display("FAIL rst_state got=%0d exp=0", bus.state); end
    checks++; if (bus.count !== 5'd0) begin failures++; $display("FAIL rst_count got=%0d exp=0", bus.count); end
    checks++; if (bus.rd_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", bus.rd_valid); end
    checks++; if (bus.overflow !== 1'b0 || bus.triggered !== 1'b0) begin failures++; $display("FAIL rst_flags got=%b%b exp=00", bus.overflow, bus.triggered); end
    checks++; if ({bus.rd_stamp, bus.rd_addr, bus.rd_data} !== 35'd0) begin failures++; $display("FAIL rst_head got=%h exp=0", {bus.rd_stamp, bus.rd_addr, bus.rd_data}); end
    step();
    checks++; if (bus.state !== 2'd0) begin failures++; $display("FAIL idle_hold got=%0d exp=0", bus.state); end
  endtask

  task automatic test_basic();
    int s;
    pulse_start();
    checks++; if (bus.state !== 2'd1) begin failures++; $display("FAIL t1_state got=%0d exp=1", bus.state); end
    s = m_stamp;
    do_write(3'd1, 16'h0011);
    step(); step();
    do_write(3'd2, 16'h0022);
    checks++; if (bus.count !== 5'd2) begin failures++; $display("FAIL t1_count got=%0d exp=2", bus.count); end
    checks++; if (bus.rd_addr !== 3'd1 || bus.rd_data !== 16'h0011) begin failures++; $display("FAIL t1_head got=%0d/%h exp=1/0011", bus.rd_addr, bus.rd_data); end
    checks++; if (bus.rd_stamp !== 16'(s)) begin failures++; $display("FAIL t1_stamp0 got=%h exp=%h", bus.rd_stamp, 16'(s)); end
    bus.rd_ready = 1'b1; step();
    checks++; if (bus.rd_addr !== 3'd2 || bus.rd_data !== 16'h0022) begin failures++; $display("FAIL t1_pop1 got=%0d/%h exp=2/0022", bus.rd_addr, bus.rd_data); end
    checks++; if (bus.rd_stamp !== 16'(s + 3)) begin failures++; $display("FAIL t1_stamp1 got=%h exp=%h", bus.rd_stamp, 16'(s + 3)); end
    step();
    checks++; if (bus.rd_valid !== 1'b0 || bus.rd_data !== 16'd0) begin failures++; $display("FAIL t1_empty got=%b/%h exp=0/0", bus.rd_valid, bus.rd_data); end
    step();
    checks++; if (bus.count !== 5'd0) begin failures++; $display("FAIL t1_empty_pop got=%0d exp=0", bus.count); end
    bus.rd_ready = 1'b0;
  endtask

  task automatic test_overflow();
    int s0;
    logic [15:0] d0;
    pulse_start();
    s0 = m_stamp; d0 = 16'($urandom);
    do_write(3'd0, d0);
    for (int i = 1; i < 17; i++) do_write(3'(i), 16'($urandom));
    checks++; if (bus.count !== 5'd16) begin failures++; $display("FAIL t2_count got=%0d exp=16", bus.count); end
    checks++; if (bus.overflow !== 1'b1) begin failures++; $display("FAIL t2_ovf got=%b exp=1", bus.overflow); end
    checks++; if (bus.rd_data !== d0 || bus.rd_stamp !== 16'(s0)) begin failures++; $display("FAIL t2_head got=%h@%h exp=%h@%h", bus.rd_data, bus.rd_stamp, d0, 16'(s0)); end
    pulse_start();
    checks++; if (bus.count !== 5'd0 || bus.overflow !== 1'b0 || bus.rd_valid !== 1'b0) begin failures++; $display("FAIL t2_flush got=%0d/%b/%b exp=0/0/0", bus.count, bus.overflow, bus.rd_valid); end
  endtask

  task automatic test_full_pushpop();
    int sn;
    for (int i = 0; i < 16; i++) do_write(3'(i), 16'h3000 + 16'(i));
    checks++; if (bus.count !== 5'd16 || bus.overflow !== 1'b0) begin failures++; $display("FAIL t3_full got=%0d/%b exp=16/0", bus.count, bus.overflow); end
    sn = m_stamp;
    bus.rd_ready = 1'b1;
    do_write(3'd7, 16'hA5A5);
    bus.rd_ready = 1'b0;
    checks++; if (bus.count !== 5'd16 || bus.overflow !== 1'b0) begin failures++; $display("FAIL t3_pushpop got=%0d/%b exp=16/0", bus.count, bus.overflow); end
    checks++; if (bus.rd_data !== 16'h3001) begin failures++; $display("FAIL t3_head got=%h exp=3001", bus.rd_data); end
    bus.rd_ready = 1'b1;
    for (int i = 0; i < 15; i++) step();
    bus.rd_ready = 1'b0;
    checks++; if (bus.count !== 5'd1) begin failures++; $display("FAIL t3_drain got=%0d exp=1", bus.count); end
    checks++; if (bus.rd_addr !== 3'd7 || bus.rd_data !== 16'hA5A5 || bus.rd_stamp !== 16'(sn)) begin failures++; $display("FAIL t3_tail got=%0d/%h@%h exp=7/a5a5@%h", bus.rd_addr, bus.rd_data, bus.rd_stamp, 16'(sn)); end
    bus.rd_ready = 1'b1; step(); bus.rd_ready = 1'b0;
  endtask

  task automatic test_trigger();
    logic [2:0] exp_a [4];
    exp_a = '{3'd3, 3'd5, 3'd6, 3'd7};
    bus.trig_en = 1'b1; bus.trig_addr = 3'd5; bus.post_cnt = 4'd2;
    pulse_start();
    do_write(3'd3, 16'h0303);
    checks++; if (bus.state !== 2'd1 || bus.triggered !== 1'b0) begin failures++; $display("FAIL t4_pre got=%0d/%b exp=1/0", bus.state, bus.triggered); end
    do_write(3'd5, 16'h0505);
    checks++; if (bus.state !== 2'd2 || bus.triggered !== 1'b1) begin failures++; $display("FAIL t4_trig got=%0d/%b exp=2/1", bus.state, bus.triggered); end
    do_write(3'd6, 16'h0606);
    checks++; if (bus.state !== 2'd2) begin failures++; $display("FAIL t4_post1 got=%0d exp=2", bus.state); end
    do_write(3'd7, 16'h0707);
    checks++; if (bus.state !== 2'd3) begin failures++; $display("FAIL t4_done got=%0d exp=3", bus.state); end
    do_write(3'd1, 16'h0101);
    checks++; if (bus.state !== 2'd3 || bus.count !== 5'd4) begin failures++; $display("FAIL t4_frozen got=%0d/%0d exp=3/4", bus.state, bus.count); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (bus.rd_addr !== exp_a[i]) begin failures++; $display("FAIL t4_order%0d got=%0d exp=%0d", i, bus.rd_addr, exp_a[i]); end
      bus.rd_ready = 1'b1; step(); bus.rd_ready = 1'b0;
    end
    checks++; if (bus.rd_valid !== 1'b0) begin failures++; $display("FAIL t4_drained got=%b exp=0", bus.rd_valid); end
  endtask

  task automatic test_post_zero_stop_start();
    bus.trig_en = 1'b1; bus.trig_addr = 3'd5; bus.post_cnt = 4'd0;
    pulse_start();
    do_write(3'd2, 16'h0202);
    do_write(3'd5, 16'h0505);
    checks++; if (bus.state !== 2'd3 || bus.triggered !== 1'b1 || bus.count !== 5'd2) begin failures++; $display("FAIL t5_done got=%0d/%b/%0d exp=3/1/2", bus.state, bus.triggered, bus.count); end
    do_write(3'd5, 16'h5555);
    checks++; if (bus.count !== 5'd2) begin failures++; $display("FAIL t5_nocap got=%0d exp=2", bus.count); end
    bus.start = 1'b1; bus.stop = 1'b1; step(); bus.start = 1'b0; bus.stop = 1'b0;
    checks++; if (bus.state !== 2'd0 || bus.count !== 5'd2 || bus.rd_addr !== 3'd2) begin failures++; $display("FAIL t5_stopstart got=%0d/%0d/%0d exp=0/2/2", bus.state, bus.count, bus.rd_addr); end
  endtask

  task automatic test_reset_mid_post();
    bus.trig_en = 1'b1; bus.trig_addr = 3'd5; bus.post_cnt = 4'd9;
    pulse_start();
    do_write(3'd5, 16'h5005);
    for (int i = 0; i < 4; i++) do_write(3'd1, 16'($urandom));
    checks++; if (bus.state !== 2'd2 || bus.count !== 5'd5) begin failures++; $display("FAIL t6_pre got=%0d/%0d exp=2/5", bus.state, bus.count); end
    reset = 1'b1; step(); reset = 1'b0;
    checks++; if (bus.state !== 2'd0 || bus.count !== 5'd0 || bus.rd_valid !== 1'b0 || bus.triggered !== 1'b0) begin failures++; $display("FAIL t6_reset got=%0d/%0d/%b/%b exp=0/0/0/0", bus.state, bus.count, bus.rd_valid, bus.triggered); end
    bus.trig_en = 1'b0;
    pulse_start();
    do_write(3'd4, 16'h4444);
    checks++; if (bus.rd_stamp !== 16'd1) begin failures++; $display("FAIL t6_stamp got=%h exp=0001", bus.rd_stamp); end
  endtask

  task automatic test_stamp_wrap();
    for (int i = 0; i < 65534; i++) step();
    bus.rd_ready = 1'b1;
    do_write(3'd6, 16'hBEEF);
    bus.rd_ready = 1'b0;
    checks++; if (bus.count !== 5'd1 || bus.rd_addr !== 3'd6) begin failures++; $display("FAIL wrap_entry got=%0d/%0d exp=1/6", bus.count, bus.rd_addr); end
    checks++; if (bus.rd_stamp !== 16'h0000) begin failures++; $display("FAIL wrap_stamp got=%h exp=0000", bus.rd_stamp); end
  endtask

  task automatic test_random();
    ent_t h;
    int   rd_pct;
    for (int i = 0; i < 3000; i++) begin
      rd_pct = (i < 1500) ? 40 : 80;
      bus.write_en   = ($urandom_range(0, 99) < 60);
      bus.wback_addr = 3'($urandom_range(0, 7));
      bus.reg_w_data = 16'($urandom);
      bus.rd_ready   = ($urandom_range(0, 99) < rd_pct);
      bus.start      = ($urandom_range(0, 99) == 0);
      bus.stop       = ($urandom_range(0, 149) == 0);
      bus.trig_en    = ($urandom_range(0, 3) != 0);
      bus.trig_addr  = 3'($urandom_range(0, 7));
      bus.post_cnt   = 4'($urandom_range(0, 15));
      reset          = ($urandom_range(0, 499) == 0);
      step();
      h = (mq.size() != 0) ? mq[0] : '0;
      checks++; if (bus.count !== (AW + 1)'(mq.size())) begin failures++; $display("FAIL rnd_count cyc=%0d got=%0d exp=%0d", i, bus.count, mq.size()); end
      checks++; if (bus.rd_valid !== (mq.size() != 0)) begin failures++; $display("FAIL rnd_valid cyc=%0d got=%b", i, bus.rd_valid); end
      checks++; if ({bus.rd_stamp, bus.rd_addr, bus.rd_data} !== h) begin failures++; $display("FAIL rnd_head cyc=%0d got=%h exp=%h", i, {bus.rd_stamp, bus.rd_addr, bus.rd_data}, h); end
      checks++; if (bus.state !== 2'(m_state)) begin failures++; $display("FAIL rnd_state cyc=%0d got=%0d exp=%0d", i, bus.state, m_state); end
      checks++; if (bus.overflow !== m_ovf || bus.triggered !== m_trig) begin failures++; $display("FAIL rnd_flags cyc=%0d got=%b%b exp=%b%b", i, bus.overflow, bus.triggered, m_ovf, m_trig); end
    end
    reset = 1'b0; bus.start = 1'b0; bus.stop = 1'b0; bus.write_en = 1'b0; bus.rd_ready = 1'b0;
  endtask

  initial begin
    checks = 0; failures = 0;
    reset = 1'b1;
    bus.write_en = 1'b0; bus.wback_addr = 3'd0; bus.reg_w_data = 16'd0;
    bus.start = 1'b0; bus.stop = 1'b0; bus.trig_en = 1'b0; bus.trig_addr = 3'd0;
    bus.post_cnt = 4'd0; bus.rd_ready = 1'b0;
    test_reset();
    test_basic();
    test_overflow();
    test_full_pushpop();
    test_trigger();
    test_post_zero_stop_start();
    test_reset_mid_post();
    test_stamp_wrap();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
